// File: rtl/ebus_arbiter.sv
// EBUS arbiter between the EBOX and the PI: grants the bus, sequences DEMAND/XFER transfers and enforces a turnaround gap.
// Optional EBUS_ARB_PARK_EN parks an idle bus on the EBOX.
module ebus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TURN_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       EBOX_REQ,
    input  logic       EBOX_REL,
    input  logic       PI_REQ,
    input  logic       PI_DONE,
    input  logic       DEMAND_REQ,
    input  logic       XFER,
    output logic       EBOX_GRANT,
    output logic       PI_GRANT,
    output logic       DEMAND,
    output logic [1:0] DRIVE_SEL,
    output logic       XFER_DONE,
    output logic       TIMEOUT,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OWN_EBOX,
        S_OWN_PI,
        S_DEMAND,
        S_XFER_WAIT_CLR,
        S_TURN
    } state_t;

    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] TURN_END = 2'(TURN_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [1:0] turn_cnt;
    logic       owner_pi;
    logic       last_pi;
`ifdef EBUS_ARB_PARK_EN
    logic       parked;
`endif

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // owner_pi remembers who started a transfer so DEMAND/XFER_WAIT_CLR can keep that grant
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt      <= 8'd0;
            turn_cnt <= 2'd0;
            owner_pi <= 1'b0;
            last_pi  <= 1'b0;
`ifdef EBUS_ARB_PARK_EN
            parked   <= 1'b0;
`endif
        end else begin
            if (state == S_DEMAND) begin
                if (cnt != 8'hFF) begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end

            if (state == S_TURN) begin
                turn_cnt <= turn_cnt + 2'd1;
            end else begin
                turn_cnt <= 2'd0;
            end

            if (state == S_IDLE || state == S_OWN_EBOX || state == S_OWN_PI) begin
                owner_pi <= (state == S_OWN_PI);
            end

            if (state == S_OWN_PI && PI_DONE) begin
                last_pi <= 1'b1;
            end else if (state == S_OWN_EBOX && EBOX_REL) begin
                last_pi <= 1'b0;
            end

`ifdef EBUS_ARB_PARK_EN
            if (state == S_IDLE) begin
                parked <= parked ? (next_state == S_IDLE) : (!PI_REQ && !EBOX_REQ);
            end else begin
                parked <= 1'b0;
            end
`endif
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
`ifdef EBUS_ARB_PARK_EN
                if (parked) begin
                    if (DEMAND_REQ) begin
                        next_state = S_DEMAND;
                    end else if (PI_REQ) begin
                        next_state = S_TURN;
                    end else if (EBOX_REQ) begin
                        next_state = S_OWN_EBOX;
                    end
                end else
`endif
                if (PI_REQ && (!EBOX_REQ || !last_pi)) begin
                    next_state = S_OWN_PI;
                end else if (EBOX_REQ) begin
                    next_state = S_OWN_EBOX;
                end
            end
            S_OWN_EBOX: begin
                if (EBOX_REL) begin
                    next_state = S_TURN;
                end else if (DEMAND_REQ) begin
                    next_state = S_DEMAND;
                end
            end
            S_OWN_PI: begin
                if (PI_DONE) begin
                    next_state = S_TURN;
                end else if (DEMAND_REQ) begin
                    next_state = S_DEMAND;
                end
            end
            // An acknowledge on the terminal-count cycle still counts as success
            S_DEMAND: begin
                if (XFER) begin
                    next_state = S_XFER_WAIT_CLR;
                end else if (cnt == TERM_CNT) begin
                    next_state = owner_pi ? S_OWN_PI : S_OWN_EBOX;
                end
            end
            S_XFER_WAIT_CLR: begin
                if (!XFER) begin
                    next_state = owner_pi ? S_OWN_PI : S_OWN_EBOX;
                end
            end
            S_TURN: begin
                if (turn_cnt == TURN_END) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        EBOX_GRANT = 1'b0;
        PI_GRANT   = 1'b0;
        DEMAND     = 1'b0;
        DRIVE_SEL  = 2'b00;
        XFER_DONE  = 1'b0;
        TIMEOUT    = 1'b0;
        BUSY       = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
`ifdef EBUS_ARB_PARK_EN
                EBOX_GRANT = parked;
                DRIVE_SEL  = parked ? 2'b01 : 2'b00;
`endif
            end
            S_OWN_EBOX: begin
                EBOX_GRANT = 1'b1;
                DRIVE_SEL  = 2'b01;
            end
            S_OWN_PI: begin
                PI_GRANT  = 1'b1;
                DRIVE_SEL = 2'b10;
            end
            S_DEMAND: begin
                EBOX_GRANT = !owner_pi;
                PI_GRANT   = owner_pi;
                DRIVE_SEL  = owner_pi ? 2'b10 : 2'b01;
                DEMAND     = 1'b1;
                XFER_DONE  = XFER;
                TIMEOUT    = !XFER && (cnt == TERM_CNT);
            end
            S_XFER_WAIT_CLR: begin
                EBOX_GRANT = !owner_pi;
                PI_GRANT   = owner_pi;
                DRIVE_SEL  = owner_pi ? 2'b10 : 2'b01;
            end
            S_TURN: begin
            end
            default: begin
            end
        endcase
    end

endmodule
